// File: rtl/opm_write_sequencer_pkg.sv
// Shared definitions for the OPM write sequencer: FSM encodings, parameter defaults
// and the buffered register/data pair layout.
package opm_write_sequencer_pkg;

    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_ADDR_SETUP = 3'd1;
    localparam logic [2:0] ST_ADDR_STB   = 3'd2;
    localparam logic [2:0] ST_GAP        = 3'd3;
    localparam logic [2:0] ST_DATA_SETUP = 3'd4;
    localparam logic [2:0] ST_DATA_STB   = 3'd5;
    localparam logic [2:0] ST_SETTLE     = 3'd6;
    localparam logic [2:0] ST_BUSY_WAIT  = 3'd7;

    localparam int DEF_DEPTH       = 16;
    localparam int DEF_STROBE_LEN  = 2;
    localparam int DEF_GAP_LEN     = 4;
    localparam int DEF_BUSY_SETTLE = 2;
    localparam int DEF_TIMEOUT     = 1023;

    typedef struct packed {
        logic [7:0] reg_addr;
        logic [7:0] data;
    } opm_pair_t;

    // A zero gap still needs one cycle so din never moves on the strobe release edge.
    function automatic int unsigned at_least_one(input int unsigned v);
        return (v == 0) ? 1 : v;
    endfunction

endpackage

// File: rtl/opm_wr_fifo.sv
// 16-bit wide synchronous FIFO holding pending register/data pairs, with occupancy output.
// Read data is the head entry, available combinationally while not empty.
module opm_wr_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic [15:0]              wdata_i,
    input  logic                     pop_i,
    output logic [15:0]              rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [15:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [LW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    assign full_o  = (count_q == LW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign level_o = count_q;
    assign rdata_o = mem[rd_ptr_q];

    assign do_pop  = pop_i & ~empty_o;
    // When full, a push is still taken if the head leaves on the same edge.
    assign do_push = push_i & (~full_o | do_pop);

    always_comb begin
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + LW'(1);
            2'b01:   count_d = count_q - LW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[wr_ptr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/opm_write_sequencer.sv
// Replays buffered OPM register writes into a jt51 as an address cycle then a data cycle,
// with strobes aligned to cen_p1 and a bounded wait on the core's busy flag.
module opm_write_sequencer
    import opm_write_sequencer_pkg::*;
#(
    parameter int DEPTH       = DEF_DEPTH,
    parameter int STROBE_LEN  = DEF_STROBE_LEN,
    parameter int GAP_LEN     = DEF_GAP_LEN,
    parameter int BUSY_SETTLE = DEF_BUSY_SETTLE,
    parameter int TIMEOUT     = DEF_TIMEOUT
) (
    input  logic                     ymclk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [7:0]               req_reg,
    input  logic [7:0]               req_data,
    input  logic                     cen_p1,
    input  logic                     opm_busy,
    output logic                     opm_cs_n,
    output logic                     opm_wr_n,
    output logic                     opm_a0,
    output logic [7:0]               opm_din,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     idle,
    output logic                     timeout_err,
    input  logic                     clr_err,
    output logic [2:0]               dbg_state_o
);
    localparam int          TW      = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
    localparam logic [7:0]  STB_L   = 8'(STROBE_LEN);
    localparam logic [7:0]  GAP_L   = 8'(at_least_one(GAP_LEN));
    localparam logic [7:0]  SET_L   = 8'(BUSY_SETTLE);

    // Request handshake: a pair is accepted on a rising edge where req_valid and req_ready are both 1.
    logic      fifo_full, fifo_empty, fifo_pop;
    logic [15:0] fifo_rdata;
    opm_pair_t head;

    assign req_ready = ~fifo_full;
    assign head      = fifo_rdata;

    opm_wr_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i   (ymclk),
        .rst_ni  (rst_n),
        .push_i  (req_valid & req_ready),
        .wdata_i ({req_reg, req_data}),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_level)
    );

    logic [2:0]    state_q, state_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic          cs_n_q, cs_n_d;
    logic          a0_q, a0_d;
    logic [7:0]    din_q, din_d;
    logic [7:0]    data_q, data_d;
    logic          err_q, err_d;
    logic          timeout_hit;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        to_cnt_d    = to_cnt_q;
        cs_n_d      = cs_n_q;
        a0_d        = a0_q;
        din_d       = din_q;
        data_d      = data_q;
        fifo_pop    = 1'b0;
        timeout_hit = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    a0_d     = 1'b0;
                    din_d    = head.reg_addr;
                    data_d   = head.data;
                    state_d  = ST_ADDR_SETUP;
                end
            end
            ST_ADDR_SETUP, ST_DATA_SETUP: begin
                if (cen_p1) begin
                    cs_n_d  = 1'b0;
                    cnt_d   = STB_L;
                    state_d = (state_q == ST_ADDR_SETUP) ? ST_ADDR_STB : ST_DATA_STB;
                end
            end
            ST_ADDR_STB: begin
                if (cnt_q <= 8'd1) begin
                    cs_n_d  = 1'b1;
                    cnt_d   = GAP_L;
                    state_d = ST_GAP;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ST_GAP: begin
                if (cnt_q <= 8'd1) begin
                    a0_d    = 1'b1;
                    din_d   = data_q;
                    state_d = ST_DATA_SETUP;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ST_DATA_STB: begin
                if (cnt_q <= 8'd1) begin
                    cs_n_d   = 1'b1;
                    to_cnt_d = '0;
                    cnt_d    = SET_L;
                    state_d  = (SET_L == 8'd0) ? ST_BUSY_WAIT : ST_SETTLE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ST_SETTLE: begin
                if (cnt_q <= 8'd1) begin
                    state_d = ST_BUSY_WAIT;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ST_BUSY_WAIT: begin
                if (!opm_busy) begin
                    state_d = ST_IDLE;
                end else if (to_cnt_q == TO_LAST) begin
                    timeout_hit = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + TW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // A fresh timeout outranks a clear landing on the same edge.
        err_d = timeout_hit ? 1'b1 : (clr_err ? 1'b0 : err_q);
    end

    always_ff @(posedge ymclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            to_cnt_q <= '0;
            cs_n_q   <= 1'b1;
            a0_q     <= 1'b0;
            din_q    <= '0;
            data_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            to_cnt_q <= to_cnt_d;
            cs_n_q   <= cs_n_d;
            a0_q     <= a0_d;
            din_q    <= din_d;
            data_q   <= data_d;
            err_q    <= err_d;
        end
    end

    assign opm_cs_n    = cs_n_q;
    assign opm_wr_n    = cs_n_q;
    assign opm_a0      = a0_q;
    assign opm_din     = din_q;
    assign idle        = (state_q == ST_IDLE) & fifo_empty;
    assign timeout_err = err_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_opm_write_sequencer.sv
// Directed bench for opm_write_sequencer: bus strobes are captured by a negedge monitor
// and compared against hand-computed pairs and timings.
module tb_opm_write_sequencer;
    import opm_write_sequencer_pkg::*;

    localparam int TIMEOUT_V = 1023;

    // ---------------- clock / reset ----------------
    logic       ymclk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [7:0] req_reg = 8'h00;
    logic [7:0] req_data = 8'h00;
    logic       cen_p1 = 1'b1;
    logic       cen_mode = 1'b0;
    logic       opm_busy = 1'b0;
    logic       opm_cs_n, opm_wr_n, opm_a0;
    logic [7:0] opm_din;
    logic [4:0] fifo_level;
    logic       idle, timeout_err;
    logic       clr_err = 1'b0;
    logic [2:0] dbg_state;

    always #5 ymclk = ~ymclk;

    // cen_p1 changes on the falling edge so it is stable around every rising edge.
    always @(negedge ymclk) begin
        if (cen_mode) cen_p1 <= ~cen_p1;
        else          cen_p1 <= 1'b1;
    end

    opm_write_sequencer dut (
        .ymclk       (ymclk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_reg     (req_reg),
        .req_data    (req_data),
        .cen_p1      (cen_p1),
        .opm_busy    (opm_busy),
        .opm_cs_n    (opm_cs_n),
        .opm_wr_n    (opm_wr_n),
        .opm_a0      (opm_a0),
        .opm_din     (opm_din),
        .fifo_level  (fifo_level),
        .idle        (idle),
        .timeout_err (timeout_err),
        .clr_err     (clr_err),
        .dbg_state_o (dbg_state)
    );

    int errors = 0;
    int checks = 0;

    // ---------------- bus monitor ----------------
    logic       cen_at_edge = 1'b1;
    logic       mon_prev_cs = 1'b1;
    logic       mon_a0 = 1'b0;
    logic [7:0] mon_din = 8'h00;
    int         mon_len = 0;
    logic       mon_cen = 1'b0;
    int         viol_cnt = 0;
    int         wrn_viol = 0;
    int         bw_run = 0;
    int         bw_last = 0;
    logic       obs_a0_q[$];
    logic [7:0] obs_din_q[$];
    int         obs_len_q[$];
    logic       obs_cen_q[$];
    logic [15:0] exp_q[$];

    always @(posedge ymclk) cen_at_edge <= cen_p1;

    always @(negedge ymclk) begin
        if (!rst_n) begin
            mon_prev_cs <= 1'b1;
            mon_len     <= 0;
        end else begin
            mon_prev_cs <= opm_cs_n;
            if (opm_cs_n == 1'b0) begin
                if (mon_prev_cs) begin
                    mon_a0  <= opm_a0;
                    mon_din <= opm_din;
                    mon_len <= 1;
                    mon_cen <= cen_at_edge;
                end else begin
                    mon_len <= mon_len + 1;
                    if (opm_a0 !== mon_a0 || opm_din !== mon_din) viol_cnt <= viol_cnt + 1;
                end
            end else if (!mon_prev_cs) begin
                if (opm_a0 !== mon_a0 || opm_din !== mon_din) viol_cnt <= viol_cnt + 1;
                obs_a0_q.push_back(mon_a0);
                obs_din_q.push_back(mon_din);
                obs_len_q.push_back(mon_len);
                obs_cen_q.push_back(mon_cen);
            end
        end
    end

    always @(negedge ymclk) begin
        if (opm_wr_n !== opm_cs_n) wrn_viol <= wrn_viol + 1;
        if (dbg_state == ST_BUSY_WAIT) begin
            bw_run <= bw_run + 1;
        end else begin
            if (bw_run > 0) bw_last <= bw_run;
            bw_run <= 0;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic clear_obs();
        obs_a0_q.delete();
        obs_din_q.delete();
        obs_len_q.delete();
        obs_cen_q.delete();
        exp_q.delete();
    endtask

    task automatic push_one(input logic [7:0] r, input logic [7:0] d, input int budget, output bit ok);
        ok = 1'b0;
        req_valid = 1'b1;
        req_reg   = r;
        req_data  = d;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge ymclk);
            if (req_ready) ok = 1'b1;
            @(posedge ymclk);
            #1;
        end
        req_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(posedge ymclk);
            #1;
            if (idle) ok = 1'b1;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge ymclk);
        #1;
        checks++; if (opm_cs_n !== 1'b1 || opm_wr_n !== 1'b1) begin errors++; $display("FAIL reset_strobe: cs_n=%b wr_n=%b want 1/1", opm_cs_n, opm_wr_n); end
        checks++; if (opm_a0 !== 1'b0 || opm_din !== 8'h00) begin errors++; $display("FAIL reset_bus: a0=%b din=%h want 0/00", opm_a0, opm_din); end
        checks++; if (fifo_level !== 5'd0 || req_ready !== 1'b1) begin errors++; $display("FAIL reset_fifo: level=%0d ready=%b want 0/1", fifo_level, req_ready); end
        checks++; if (idle !== 1'b1 || timeout_err !== 1'b0) begin errors++; $display("FAIL reset_flags: idle=%b err=%b want 1/0", idle, timeout_err); end
        @(negedge ymclk);
        rst_n = 1'b1;
        repeat (2) @(posedge ymclk);
        #1;
        checks++; if (dbg_state !== ST_IDLE || idle !== 1'b1) begin errors++; $display("FAIL reset_release: state=%0d idle=%b want 0/1", dbg_state, idle); end
    endtask

    task automatic test_single();
        bit ok;
        int gap;
        clear_obs();
        opm_busy = 1'b0;
        push_one(8'h20, 8'hC7, 4, ok);
        checks++; if (!ok) begin errors++; $display("FAIL single_push: accepted=%b want 1", ok); end
        for (int i = 0; i < 20 && opm_cs_n !== 1'b0; i++) @(negedge ymclk);
        for (int i = 0; i < 20 && opm_cs_n !== 1'b1; i++) @(negedge ymclk);
        gap = 0;
        for (int i = 0; i < 40 && opm_a0 === 1'b0 && opm_cs_n === 1'b1; i++) begin
            gap++;
            @(negedge ymclk);
        end
        checks++; if (gap != 4) begin errors++; $display("FAIL single_gap: got %0d cycles want 4", gap); end
        wait_idle(100, ok);
        checks++; if (!ok) begin errors++; $display("FAIL single_idle: idle=%b want 1", idle); end
        checks++; if (obs_a0_q.size() != 2) begin errors++; $display("FAIL single_count: got %0d strobes want 2", obs_a0_q.size()); end
        if (obs_a0_q.size() >= 2) begin
            checks++; if (obs_a0_q[0] !== 1'b0 || obs_din_q[0] !== 8'h20 || obs_len_q[0] != 2) begin errors++; $display("FAIL single_addr: a0=%b din=%h len=%0d want 0/20/2", obs_a0_q[0], obs_din_q[0], obs_len_q[0]); end
            checks++; if (obs_a0_q[1] !== 1'b1 || obs_din_q[1] !== 8'hC7 || obs_len_q[1] != 2) begin errors++; $display("FAIL single_data: a0=%b din=%h len=%0d want 1/C7/2", obs_a0_q[1], obs_din_q[1], obs_len_q[1]); end
        end
        checks++; if (viol_cnt != 0 || wrn_viol != 0) begin errors++; $display("FAIL single_stable: viol=%0d wrn=%0d want 0/0", viol_cnt, wrn_viol); end
    endtask

    task automatic test_cen_toggle();
        bit ok;
        clear_obs();
        cen_mode = 1'b1;
        @(posedge ymclk);
        #1;
        // Arrange acceptance on an edge where cen_p1 is low (it toggles before that edge).
        if (cen_p1 !== 1'b1) begin
            @(posedge ymclk);
            #1;
        end
        push_one(8'h08, 8'h7A, 4, ok);
        checks++; if (!ok) begin errors++; $display("FAIL cen_push: accepted=%b want 1", ok); end
        wait_idle(150, ok);
        checks++; if (!ok) begin errors++; $display("FAIL cen_idle: idle=%b want 1", idle); end
        checks++; if (obs_a0_q.size() != 2) begin errors++; $display("FAIL cen_count: got %0d strobes want 2", obs_a0_q.size()); end
        if (obs_a0_q.size() >= 2) begin
            checks++; if (obs_cen_q[0] !== 1'b1 || obs_cen_q[1] !== 1'b1) begin errors++; $display("FAIL cen_align: cen at fall addr=%b data=%b want 1/1", obs_cen_q[0], obs_cen_q[1]); end
            checks++; if ({obs_a0_q[0], obs_a0_q[1], obs_din_q[0], obs_din_q[1]} !== {2'b01, 16'h087A}) begin errors++; $display("FAIL cen_pair: a0=%b%b din=%h/%h want 01 08/7A", obs_a0_q[0], obs_a0_q[1], obs_din_q[0], obs_din_q[1]); end
        end
        cen_mode = 1'b0;
        repeat (2) @(posedge ymclk);
        #1;
    endtask

    task automatic test_burst_timeout();
        bit ok;
        bit acc17;
        logic [4:0] lvl_seen;
        int fails;
        logic [15:0] e;
        clear_obs();
        opm_busy = 1'b1;
        fails = 0;
        for (int k = 0; k < 17; k++) begin
            push_one(8'h10 + 8'(k), 8'hA0 + 8'(k), 4, ok);
            if (ok) exp_q.push_back({8'h10 + 8'(k), 8'hA0 + 8'(k)});
            else fails++;
        end
        checks++; if (fails != 0) begin errors++; $display("FAIL burst_accept: %0d pushes refused want 0", fails); end
        checks++; if (fifo_level !== 5'd16 || req_ready !== 1'b0) begin errors++; $display("FAIL burst_full: level=%0d ready=%b want 16/0", fifo_level, req_ready); end
        acc17 = 1'b0;
        lvl_seen = '0;
        req_valid = 1'b1;
        req_reg   = 8'h21;
        req_data  = 8'hB1;
        for (int i = 0; i < 3000 && !acc17; i++) begin
            @(negedge ymclk);
            if (req_ready) begin
                acc17 = 1'b1;
                lvl_seen = fifo_level;
            end
            @(posedge ymclk);
            #1;
        end
        req_valid = 1'b0;
        if (acc17) exp_q.push_back(16'h21B1);
        checks++; if (!acc17 || lvl_seen !== 5'd15) begin errors++; $display("FAIL burst_17th: accepted=%b level=%0d want 1/15", acc17, lvl_seen); end
        checks++; if (bw_last != TIMEOUT_V) begin errors++; $display("FAIL burst_wait: busy wait %0d cycles want %0d", bw_last, TIMEOUT_V); end
        checks++; if (timeout_err !== 1'b1 || fifo_level !== 5'd16) begin errors++; $display("FAIL burst_err: err=%b level=%0d want 1/16", timeout_err, fifo_level); end
        opm_busy = 1'b0;
        wait_idle(2000, ok);
        checks++; if (!ok) begin errors++; $display("FAIL burst_drain: idle=%b want 1", idle); end
        checks++; if (obs_a0_q.size() != 36) begin errors++; $display("FAIL burst_count: got %0d strobes want 36", obs_a0_q.size()); end
        for (int k = 0; k < 18 && 2 * k + 1 < obs_a0_q.size() && exp_q.size() > 0; k++) begin
            e = exp_q.pop_front();
            checks++;
            if ({obs_a0_q[2*k], obs_a0_q[2*k+1], obs_din_q[2*k], obs_din_q[2*k+1]} !== {2'b01, e}) begin
                errors++;
                $display("FAIL burst_order[%0d]: a0=%b%b pair=%h%h want 01 %h", k, obs_a0_q[2*k], obs_a0_q[2*k+1], obs_din_q[2*k], obs_din_q[2*k+1], e);
            end
        end
        clr_err = 1'b1;
        @(posedge ymclk);
        #1;
        clr_err = 1'b0;
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL burst_clr: err=%b want 0", timeout_err); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        bit acc;
        int max_level, full_pop, fails;
        logic [7:0] r, d;
        logic [15:0] e;
        clear_obs();
        opm_busy = 1'b0;
        max_level = 0;
        full_pop = 0;
        fails = 0;
        for (int k = 0; k < 64; k++) begin
            r = 8'($urandom_range(0, 255));
            d = 8'($urandom_range(0, 255));
            req_valid = 1'b1;
            req_reg   = r;
            req_data  = d;
            acc = 1'b0;
            for (int i = 0; i < 200 && !acc; i++) begin
                @(negedge ymclk);
                if (int'(fifo_level) > max_level) max_level = int'(fifo_level);
                if (fifo_level == 5'd16 && dbg_state == ST_IDLE) full_pop++;
                if (req_ready) acc = 1'b1;
                @(posedge ymclk);
                #1;
            end
            if (acc) exp_q.push_back({r, d});
            else fails++;
        end
        req_valid = 1'b0;
        checks++; if (fails != 0) begin errors++; $display("FAIL b2b_accept: %0d pushes timed out want 0", fails); end
        checks++; if (max_level != 16 || full_pop == 0) begin errors++; $display("FAIL b2b_full: max level=%0d pops at full=%0d want 16/>0", max_level, full_pop); end
        wait_idle(2000, ok);
        checks++; if (!ok) begin errors++; $display("FAIL b2b_drain: idle=%b want 1", idle); end
        checks++; if (obs_a0_q.size() != 128) begin errors++; $display("FAIL b2b_count: got %0d strobes want 128", obs_a0_q.size()); end
        for (int k = 0; k < 64 && 2 * k + 1 < obs_a0_q.size() && exp_q.size() > 0; k++) begin
            e = exp_q.pop_front();
            checks++;
            if ({obs_a0_q[2*k], obs_a0_q[2*k+1], obs_din_q[2*k], obs_din_q[2*k+1]} !== {2'b01, e}) begin
                errors++;
                $display("FAIL b2b_order[%0d]: a0=%b%b pair=%h%h want 01 %h", k, obs_a0_q[2*k], obs_a0_q[2*k+1], obs_din_q[2*k], obs_din_q[2*k+1], e);
            end
        end
        checks++; if (viol_cnt != 0 || wrn_viol != 0) begin errors++; $display("FAIL b2b_stable: viol=%0d wrn=%0d want 0/0", viol_cnt, wrn_viol); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        bit hit;
        int low_cnt;
        clear_obs();
        opm_busy = 1'b0;
        push_one(8'h30, 8'h11, 4, ok);
        push_one(8'h31, 8'h22, 4, ok);
        push_one(8'h32, 8'h33, 4, ok);
        hit = 1'b0;
        for (int i = 0; i < 60 && !hit; i++) begin
            @(posedge ymclk);
            #1;
            if (dbg_state == ST_DATA_STB) hit = 1'b1;
        end
        checks++; if (!hit || fifo_level !== 5'd2 || opm_cs_n !== 1'b0) begin errors++; $display("FAIL rstmid_pre: in data strobe=%b level=%0d cs_n=%b want 1/2/0", hit, fifo_level, opm_cs_n); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (opm_cs_n !== 1'b1 || opm_wr_n !== 1'b1) begin errors++; $display("FAIL rstmid_async: cs_n=%b wr_n=%b want 1/1", opm_cs_n, opm_wr_n); end
        checks++; if (fifo_level !== 5'd0 || dbg_state !== ST_IDLE || idle !== 1'b1) begin errors++; $display("FAIL rstmid_state: level=%0d state=%0d idle=%b want 0/0/1", fifo_level, dbg_state, idle); end
        repeat (2) @(negedge ymclk);
        clear_obs();
        rst_n = 1'b1;
        low_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge ymclk);
            if (opm_cs_n !== 1'b1) low_cnt++;
        end
        checks++; if (low_cnt != 0 || obs_a0_q.size() != 0) begin errors++; $display("FAIL rstmid_quiet: low cycles=%0d strobes=%0d want 0/0", low_cnt, obs_a0_q.size()); end
        @(posedge ymclk);
        #1;
        push_one(8'h55, 8'hAA, 4, ok);
        wait_idle(100, ok);
        checks++;
        if (!ok || obs_a0_q.size() != 2 || {obs_din_q[0], obs_din_q[1]} !== 16'h55AA) begin
            errors++;
            $display("FAIL rstmid_resume: idle=%b strobes=%0d want 1/2 with pair 55AA", ok, obs_a0_q.size());
        end
    endtask

    task automatic test_timeout_clr();
        bit ok;
        bit hit;
        opm_busy = 1'b1;
        push_one(8'h40, 8'h01, 4, ok);
        hit = 1'b0;
        for (int i = 0; i < 1500 && !hit; i++) begin
            @(posedge ymclk);
            #1;
            if (timeout_err) hit = 1'b1;
        end
        checks++; if (!hit) begin errors++; $display("FAIL to_first: err=%b want 1", timeout_err); end
        push_one(8'h41, 8'h02, 4, ok);
        clr_err = 1'b1;
        repeat (3) @(posedge ymclk);
        #1;
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL to_clr_held: err=%b want 0", timeout_err); end
        hit = 1'b0;
        for (int i = 0; i < 100 && !hit; i++) begin
            @(posedge ymclk);
            #1;
            if (dbg_state == ST_BUSY_WAIT) hit = 1'b1;
        end
        for (int i = 0; i < 1500 && hit; i++) begin
            @(posedge ymclk);
            #1;
            if (dbg_state != ST_BUSY_WAIT) hit = 1'b0;
        end
        clr_err = 1'b0;
        checks++; if (hit || timeout_err !== 1'b1) begin errors++; $display("FAIL to_set_wins: still waiting=%b err=%b want 0/1", hit, timeout_err); end
        @(posedge ymclk);
        #1;
        checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL to_sticky: err=%b want 1", timeout_err); end
        clr_err = 1'b1;
        @(posedge ymclk);
        #1;
        clr_err = 1'b0;
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL to_clear: err=%b want 0", timeout_err); end
        opm_busy = 1'b0;
        wait_idle(100, ok);
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_single();
        test_cen_toggle();
        test_burst_timeout();
        test_back_to_back();
        test_reset_mid();
        test_timeout_clr();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end

endmodule
